// File: rtl/mul_div_seq.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO pair; one shift-add or
// restoring shift-subtract step per cycle, then a sign-fix cycle.
module mul_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]         state;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   acc_hi;   // product upper half / partial remainder
  logic [WIDTH-1:0]   acc_lo;   // multiplier bits / dividend-then-quotient
  logic [WIDTH-1:0]   opb;      // multiplicand / divisor magnitude
  logic               is_div, neg_res, neg_rem, bzero;

  logic               sgn;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo, rem;

  assign busy  = (state != IDLE);
  assign sgn   = (op == 3'd0) || (op == 3'd2);
  assign abs_a = (sgn && a[WIDTH-1]) ? -a : a;
  assign abs_b = (sgn && b[WIDTH-1]) ? -b : b;

  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
  assign div_sh   = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge   = div_sh >= {1'b0, opb};
  // When the subtract succeeds the result is below the divisor, so WIDTH bits suffice
  assign div_diff = div_sh[WIDTH-1:0] - opb;

  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = neg_res ? -prod : prod;
  assign quo      = neg_res ? -acc_lo : acc_lo;
  assign rem      = neg_rem ? -acc_hi : acc_hi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      opb     <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      bzero   <= 1'b0;
      done    <= 1'b0;
      div0    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !cancel) begin
            if (op <= 3'd3) begin
              state   <= CALC;
              count   <= CW'(WIDTH - 1);
              div0    <= 1'b0;
              is_div  <= op[1];
              acc_hi  <= '0;
              acc_lo  <= op[1] ? abs_a : abs_b;
              opb     <= op[1] ? abs_b : abs_a;
              neg_res <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_rem <= sgn && op[1] && a[WIDTH-1];
              bzero   <= (b == '0);
            end else if (op == 3'd4) begin
              hi <= a;
            end else if (op == 3'd5) begin
              lo <= a;
            end
          end
        end
        CALC: begin
          if (cancel) begin
            state <= IDLE;
          end else begin
            if (is_div) begin
              acc_hi <= div_ge ? div_diff : div_sh[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
            end else begin
              acc_hi <= mul_sum[WIDTH:1];
              acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end
            if (count == '0) state <= FIX;
            else             count <= count - 1'b1;
          end
        end
        FIX: begin
          state <= IDLE;
          if (!cancel) begin
            done <= 1'b1;
            if (is_div) begin
              // Zero divisor leaves the dividend in the remainder; the quotient is forced to all ones
              hi   <= rem;
              lo   <= bzero ? '1 : quo;
              div0 <= bzero;
            end else begin
              {hi, lo} <= prod_fix;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_div_seq.sv
// Bench for mul_div_seq: directed cases with literal results, then random ops
// checked every cycle against a latency-counting arithmetic model.
module tb_mul_div_seq;
  localparam int W = 32;

  logic         clk = 1'b0, rst_n = 1'b1, start = 1'b0, cancel = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, div0;
  logic [W-1:0] hi, lo;

  mul_div_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference results straight from integer arithmetic
  task automatic ref_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [W-1:0] rh, output logic [W-1:0] rl, output logic rz);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    rz = 1'b0;
    rh = '0;
    rl = '0;
    case (o)
      3'd0: begin p = 64'(sx * sy); rh = p[63:32]; rl = p[31:0]; end
      3'd1: begin p = {32'b0, x} * {32'b0, y}; rh = p[63:32]; rl = p[31:0]; end
      default: begin
        if (y == '0) begin
          rh = x; rl = '1; rz = 1'b1;
        end else if (o == 3'd2) begin
          q = sx / sy; r = sx % sy;
          rl = W'(q); rh = W'(r);
        end else begin
          rl = x / y; rh = x % y;
        end
      end
    endcase
  endtask

  int           m_left = 0;
  logic         m_busy = 0, m_done = 0, m_div0 = 0, p_div0 = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

  // Model: an accepted op completes W+1 edges later unless cancelled
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_busy = 0; m_done = 0; m_div0 = 0; m_hi = '0; m_lo = '0;
    end else begin
      m_done = 0;
      if (m_left > 0) begin
        if (cancel) begin
          m_left = 0; m_busy = 0;
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_busy = 0; m_done = 1; m_hi = p_hi; m_lo = p_lo; m_div0 = p_div0;
          end
        end
      end else if (start && !cancel) begin
        if (op <= 3'd3) begin
          ref_op(op, a, b, p_hi, p_lo, p_div0);
          m_left = W + 1; m_busy = 1; m_div0 = 0;
        end else if (op == 3'd4) m_hi = a;
        else if (op == 3'd5) m_lo = a;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", {63'b0, busy}, {63'b0, m_busy});
      chk("done", {63'b0, done}, {63'b0, m_done});
      chk("div0", {63'b0, div0}, {63'b0, m_div0});
      chk("hi", {32'b0, hi}, {32'b0, m_hi});
      chk("lo", {32'b0, lo}, {32'b0, m_lo});
    end
  end

  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(posedge clk); #1 start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(output int nb);
    bit seen;
    nb = 0;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
      else if (busy) nb++;
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL wait_done: no done pulse within 100 cycles");
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'h8000_0000;
      2: return '1;
      3: return W'($urandom_range(0, 15));
      4: return W'(-int'($urandom_range(1, 15)));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    int nb, kc;
    #1 rst_n = 1'b0;
    #20;
    chk("rst busy", {63'b0, busy}, 64'd0);
    chk("rst done", {63'b0, done}, 64'd0);
    chk("rst div0", {63'b0, div0}, 64'd0);
    chk("rst hi", {32'b0, hi}, 64'd0);
    chk("rst lo", {32'b0, lo}, 64'd0);
    @(negedge clk); #2 rst_n = 1'b1;

    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done(nb);
    chk("t1 busy cycles", 64'(nb), 64'd33);
    chk("t1 hi", {32'b0, hi}, 64'hFFFF_FFFE);
    chk("t1 lo", {32'b0, lo}, 64'h0000_0001);

    issue(3'd0, 32'hFFFF_FFFD, 32'd7); wait_done(nb);
    chk("t2 mult hi", {32'b0, hi}, 64'hFFFF_FFFF);
    chk("t2 mult lo", {32'b0, lo}, 64'hFFFF_FFEB);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2); wait_done(nb);
    chk("t2 div lo", {32'b0, lo}, 64'hFFFF_FFFD);
    chk("t2 div hi", {32'b0, hi}, 64'hFFFF_FFFF);

    issue(3'd3, 32'd100, 32'd0); wait_done(nb);
    chk("t3 div0", {63'b0, div0}, 64'd1);
    chk("t3 hi", {32'b0, hi}, 64'd100);
    chk("t3 lo", {32'b0, lo}, 64'hFFFF_FFFF);
    issue(3'd3, 32'd100, 32'd7); wait_done(nb);
    chk("t3b div0", {63'b0, div0}, 64'd0);
    chk("t3b lo", {32'b0, lo}, 64'd14);
    chk("t3b hi", {32'b0, hi}, 64'd2);

    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF); wait_done(nb);
    chk("t4 ovf lo", {32'b0, lo}, 64'h8000_0000);
    chk("t4 ovf hi", {32'b0, hi}, 64'd0);
    issue(3'd4, 32'h1234, 32'd0);
    @(negedge clk);
    chk("t4 mthi hi", {32'b0, hi}, 64'h1234);
    chk("t4 mthi done", {63'b0, done}, 64'd0);

    issue(3'd3, 32'd1000, 32'd3);
    repeat (2) @(posedge clk);
    #1 start = 1'b1; op = 3'd1; a = 32'd5; b = 32'd5;
    @(posedge clk); #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #1 cancel = 1'b1;
    @(posedge clk); #1 cancel = 1'b0;
    @(negedge clk);
    chk("t5 busy", {63'b0, busy}, 64'd0);
    chk("t5 done", {63'b0, done}, 64'd0);
    chk("t5 hi", {32'b0, hi}, 64'h1234);
    chk("t5 lo", {32'b0, lo}, 64'h8000_0000);

    issue(3'd3, 32'd555, 32'd7);
    repeat (5) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t6 busy", {63'b0, busy}, 64'd0);
    chk("t6 done", {63'b0, done}, 64'd0);
    chk("t6 hi", {32'b0, hi}, 64'd0);
    chk("t6 lo", {32'b0, lo}, 64'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    issue(3'd2, 32'hFFFF_FF9C, 32'd9); wait_done(nb);
    chk("t6 div lo", {32'b0, lo}, 64'hFFFF_FFF5);
    chk("t6 div hi", {32'b0, hi}, 64'hFFFF_FFFF);

    for (int n = 0; n < 1200; n++) begin
      @(posedge clk); #1
      start = 1'b1; op = 3'($urandom_range(0, 7)); a = pick(); b = pick();
      cancel = ($urandom_range(0, 15) == 0);
      @(posedge clk); #1 start = 1'b0; cancel = 1'b0;
      kc = $urandom_range(0, 60);
      for (int c = 0; c < 36; c++) begin
        @(posedge clk); #1
        cancel = (c == kc);
        start  = (c == 4) && ($urandom_range(0, 3) == 0);
      end
      cancel = 1'b0; start = 1'b0;
    end
    repeat (40) @(posedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
